// File: rtl/man_decoder_pkg.sv
// Shared types, widths and the jitter-window helper for the Manchester decoder.
// Also holds the default PRBS polynomial used by the MAN_DECODER_PRBS_CHK_EN checker.
package man_pkg;

   localparam int CW = 13;
   localparam logic [8:0] PRBS_POLY = 9'h11D;

   typedef enum logic {
      HUNT,
      TRACK
   } state_t;

   typedef struct packed {
      logic [CW:0] q3;
      logic [CW:0] q5;
   } thresh_t;

   // Acceptance window for a mid-bit edge: three quarters to five quarters of a bit.
   function automatic thresh_t bit_thresholds(input logic [CW-1:0] div);
      logic [CW:0] d;
      thresh_t t;
      d = {1'b0, div};
      t.q3 = d - (d >> 2);
      t.q5 = d + (d >> 2);
      return t;
   endfunction

endpackage

// File: rtl/man_decoder_prbs_checker.sv
// Self-synchronizing PRBS checker fed by decoded bits while the decoder is locked.
// Only instantiated when MAN_DECODER_PRBS_CHK_EN is defined.
module prbs_checker #(
   parameter int         W    = 8,
   parameter logic [W:0] POLY = 9'h11D
) (
   input  logic        clk,
   input  logic        arst,
   input  logic        bit_valid,
   input  logic        bit_in,
   input  logic        locked,
   input  logic        loss,
   input  logic        clr_cnt,
   output logic        prbs_err,
   output logic [15:0] err_cnt,
   output logic        prbs_sync
);

   localparam int FW = $clog2(W + 1);
   localparam logic [FW-1:0] FILL_LAST = FW'(W - 1);

   logic [W-1:0]  hist;
   logic [FW-1:0] fill;
   logic          pred;

   // hist[0] is the newest bit, so hist[d-1] is the bit d positions back.
   assign pred = ^(POLY[W:1] & hist);

   // The first W locked bits only seed the history; checking starts afterwards.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         hist      <= '0;
         fill      <= '0;
         prbs_sync <= 1'b0;
         prbs_err  <= 1'b0;
         err_cnt   <= '0;
      end else begin
         prbs_err <= 1'b0;
         if (loss) begin
            hist      <= '0;
            fill      <= '0;
            prbs_sync <= 1'b0;
         end else if (bit_valid && locked) begin
            hist <= {hist[W-2:0], bit_in};
            if (prbs_sync) begin
               if (bit_in != pred) begin
                  prbs_err <= 1'b1;
                  if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
               end
            end else if (fill == FILL_LAST) begin
               prbs_sync <= 1'b1;
            end else begin
               fill <= fill + 1'b1;
            end
         end
         if (clr_cnt) err_cnt <= '0;
      end
   end

endmodule

// File: rtl/man_decoder.sv
// Oversampling Manchester decoder: locks onto mid-bit edges using a runtime bit period.
// Define MAN_DECODER_PRBS_CHK_EN to add the PRBS error checker and its ports.
module man_decoder
   import man_pkg::*;
#(
   parameter int LOCK_BITS = 4
`ifdef MAN_DECODER_PRBS_CHK_EN
   ,
   parameter int         W    = 8,
   parameter logic [W:0] POLY = PRBS_POLY
`endif
) (
   input  logic          clk,
   input  logic          arst,
   input  logic [CW-1:0] div,
   input  logic          line_in,
   output logic          bit_out,
   output logic          bit_valid,
   output logic          locked,
   output logic          loss
`ifdef MAN_DECODER_PRBS_CHK_EN
   ,
   input  logic          clr_cnt,
   output logic          prbs_err,
   output logic [15:0]   err_cnt,
   output logic          prbs_sync
`endif
);

   localparam logic [3:0] LOCK_N = 4'(LOCK_BITS);

   logic        s1, s2, prev;
   logic        edge_q, bit_q;
   state_t      state, state_d;
   logic [CW:0] cnt, cnt_d, elapsed;
   logic [3:0]  good, good_d;
   logic        emit, loss_d, locked_d;
   logic        in_win, late;
   thresh_t     th;

   // Edge and the pre-edge level are registered so the FSM sees a clean one-cycle event.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         prev   <= 1'b0;
         edge_q <= 1'b0;
         bit_q  <= 1'b0;
      end else begin
         s1     <= line_in;
         s2     <= s1;
         prev   <= s2;
         edge_q <= s2 ^ prev;
         bit_q  <= prev;
      end
   end

   // elapsed includes the current cycle, so it equals the edge-to-edge spacing.
   assign elapsed = (&cnt) ? cnt : cnt + 1'b1;
   assign th      = bit_thresholds(div);
   assign in_win  = (elapsed >= th.q3) && (elapsed <= th.q5);
   assign late    = elapsed > th.q5;

   always_comb begin
      state_d = state;
      cnt_d   = elapsed;
      good_d  = good;
      emit    = 1'b0;
      loss_d  = 1'b0;
      case (state)
         HUNT: begin
            if (edge_q) begin
               cnt_d = '0;
               if (in_win) begin
                  emit    = 1'b1;
                  good_d  = 4'd1;
                  state_d = TRACK;
               end
            end
         end
         TRACK: begin
            if (edge_q && in_win) begin
               emit  = 1'b1;
               cnt_d = '0;
               if (good < LOCK_N) good_d = good + 4'd1;
            end else if (!edge_q && late) begin
               loss_d  = 1'b1;
               good_d  = '0;
               state_d = HUNT;
            end
         end
         default: state_d = HUNT;
      endcase
      locked_d = (state_d == TRACK) && (good_d == LOCK_N);
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state     <= HUNT;
         cnt       <= '0;
         good      <= '0;
         bit_out   <= 1'b0;
         bit_valid <= 1'b0;
         locked    <= 1'b0;
         loss      <= 1'b0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         good      <= good_d;
         bit_out   <= emit ? bit_q : 1'b0;
         bit_valid <= emit;
         locked    <= locked_d;
         loss      <= loss_d;
      end
   end

`ifdef MAN_DECODER_PRBS_CHK_EN
   prbs_checker #(
      .W    (W),
      .POLY (POLY)
   ) u_prbs_checker (
      .clk       (clk),
      .arst      (arst),
      .bit_valid (bit_valid),
      .bit_in    (bit_out),
      .locked    (locked),
      .loss      (loss),
      .clr_cnt   (clr_cnt),
      .prbs_err  (prbs_err),
      .err_cnt   (err_cnt),
      .prbs_sync (prbs_sync)
   );
`endif

endmodule

// File: tb/tb_man_decoder.sv
// Directed bench for man_decoder: decode, phase hunt, jitter window, loss, reset, PRBS checker.
// The PRBS scenario is compiled only with MAN_DECODER_PRBS_CHK_EN.
`timescale 1ns/1ps
module tb_man_decoder;
   import man_pkg::*;

   logic          clk = 1'b0;
   logic          arst = 1'b1;
   logic [CW-1:0] div = 13'd16;
   logic          line_in = 1'b0;
   logic          bit_out, bit_valid, locked, loss;
`ifdef MAN_DECODER_PRBS_CHK_EN
   logic          clr_cnt = 1'b0;
   logic          prbs_err, prbs_sync;
   logic [15:0]   err_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic bv_bits[$];
   int   bv_cyc[$];
   logic bv_lock[$];
   int   loss_q[$];
   int   rise_q[$];
   int   fall_q[$];
   int   mid_q[$];
   int   perr_n = 0;
   logic locked_p = 1'b0;
   logic prbs[48];
   int   b0, l0, r0, f0;

   man_decoder dut (
      .clk       (clk),
      .arst      (arst),
      .div       (div),
      .line_in   (line_in),
      .bit_out   (bit_out),
      .bit_valid (bit_valid),
      .locked    (locked),
      .loss      (loss)
`ifdef MAN_DECODER_PRBS_CHK_EN
      ,
      .clr_cnt   (clr_cnt),
      .prbs_err  (prbs_err),
      .err_cnt   (err_cnt),
      .prbs_sync (prbs_sync)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Event recorder sampled on the falling edge.
   always @(negedge clk) begin
      if (bit_valid) begin
         bv_bits.push_back(bit_out);
         bv_cyc.push_back(cyc);
         bv_lock.push_back(locked);
      end
      if (loss) loss_q.push_back(cyc);
      if (locked && !locked_p) rise_q.push_back(cyc);
      if (!locked && locked_p) fall_q.push_back(cyc);
      locked_p = locked;
`ifdef MAN_DECODER_PRBS_CHK_EN
      if (prbs_err) perr_n++;
`endif
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic snapshot();
      b0 = bv_bits.size();
      l0 = loss_q.size();
      r0 = rise_q.size();
      f0 = fall_q.size();
   endtask

   task automatic do_reset();
      arst    = 1'b1;
      line_in = 1'b0;
`ifdef MAN_DECODER_PRBS_CHK_EN
      clr_cnt = 1'b0;
`endif
      repeat (3) @(negedge clk);
      arst = 1'b0;
      repeat (30) @(negedge clk);
      snapshot();
   endtask

   // Manchester encoder: 1 is high-then-low, 0 is low-then-high; div=16 gives 8-cycle halves.
   task automatic send_bit(input logic b);
      line_in = b;
      repeat (8) @(negedge clk);
      line_in = ~b;
      mid_q.push_back(cyc);
      repeat (8) @(negedge clk);
   endtask

   task automatic toggle_after(input int gap);
      repeat (gap) @(negedge clk);
      line_in = ~line_in;
   endtask

   task automatic build_prbs();
      logic [7:0] seed_bits;
      seed_bits = 8'b1011_0001;
      for (int k = 0; k < 8; k++) prbs[k] = seed_bits[7-k];
      for (int k = 8; k < 48; k++)
         prbs[k] = prbs[k-8] ^ prbs[k-4] ^ prbs[k-3] ^ prbs[k-2];
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (bit_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_bit_valid: got %b expected 0", bit_valid); end
      checks++;
      if (bit_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_bit_out: got %b expected 0", bit_out); end
      checks++;
      if (locked !== 1'b0) begin errors++; $display("[TB] FAIL reset_locked: got %b expected 0", locked); end
      checks++;
      if (loss !== 1'b0) begin errors++; $display("[TB] FAIL reset_loss: got %b expected 0", loss); end
   endtask

   task automatic test_nominal();
      int m0;
      do_reset();
      m0 = mid_q.size();
      send_bit(1'b0);
      send_bit(1'b1);
      for (int k = 0; k < 10; k++) send_bit(prbs[k]);
      repeat (6) @(negedge clk);
      checks++;
      if (bv_bits.size() - b0 !== 11) begin
         errors++;
         $display("[TB] FAIL nominal_count: got %0d bits expected 11", bv_bits.size() - b0);
      end else begin
         for (int k = 0; k < 8; k++) begin
            checks++;
            if (bv_bits[b0+1+k] !== prbs[k]) begin
               errors++;
               $display("[TB] FAIL nominal_bit%0d: got %b expected %b", k, bv_bits[b0+1+k], prbs[k]);
            end
         end
         checks++;
         if (bv_lock[b0+2] !== 1'b0) begin errors++; $display("[TB] FAIL nominal_lock3: got %b expected 0", bv_lock[b0+2]); end
         checks++;
         if (bv_lock[b0+3] !== 1'b1) begin errors++; $display("[TB] FAIL nominal_lock4: got %b expected 1", bv_lock[b0+3]); end
         for (int k = 0; k < 10; k++) begin
            checks++;
            if (bv_cyc[b0+k+1] - bv_cyc[b0+k] !== 16) begin
               errors++;
               $display("[TB] FAIL nominal_spacing%0d: got %0d expected 16", k, bv_cyc[b0+k+1] - bv_cyc[b0+k]);
            end
         end
         checks++;
         if (bv_cyc[b0+1] - mid_q[m0+2] !== 4) begin
            errors++;
            $display("[TB] FAIL nominal_latency: got %0d expected 4", bv_cyc[b0+1] - mid_q[m0+2]);
         end
      end
   endtask

   task automatic test_phase();
      int fall0;
      int ones;
      do_reset();
      toggle_after(1);
      repeat (16) @(negedge clk);
      fall0 = cyc;
      for (int k = 0; k < 5; k++) begin
         line_in = 1'b0;
         repeat (8) @(negedge clk);
         line_in = 1'b1;
         repeat (8) @(negedge clk);
      end
      repeat (6) @(negedge clk);
      checks++;
      if (bv_bits.size() - b0 !== 5) begin
         errors++;
         $display("[TB] FAIL phase_count: got %0d bits expected 5", bv_bits.size() - b0);
      end else begin
         ones = 0;
         for (int k = 0; k < 5; k++) if (bv_bits[b0+k] === 1'b1) ones++;
         checks++;
         if (ones !== 5) begin errors++; $display("[TB] FAIL phase_ones: got %0d ones expected 5", ones); end
         checks++;
         if (bv_cyc[b0] - fall0 !== 4) begin
            errors++;
            $display("[TB] FAIL phase_first: got offset %0d expected 4", bv_cyc[b0] - fall0);
         end
      end
      checks++;
      if (loss_q.size() - l0 !== 0) begin errors++; $display("[TB] FAIL phase_loss: got %0d pulses expected 0", loss_q.size() - l0); end
   endtask

   task automatic test_jitter();
      int gaps[4];
      gaps = '{12, 20, 16, 11};
      do_reset();
      toggle_after(1);
      for (int k = 0; k < 5; k++) toggle_after(16);
      for (int k = 0; k < 4; k++) toggle_after(gaps[k]);
      repeat (40) @(negedge clk);
      checks++;
      if (bv_bits.size() - b0 !== 8) begin
         errors++;
         $display("[TB] FAIL jitter_count: got %0d bits expected 8", bv_bits.size() - b0);
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (bv_cyc[b0+5+k] - bv_cyc[b0+4+k] !== gaps[k]) begin
               errors++;
               $display("[TB] FAIL jitter_gap%0d: got %0d expected %0d", gaps[k], bv_cyc[b0+5+k] - bv_cyc[b0+4+k], gaps[k]);
            end
         end
         checks++;
         if (loss_q.size() - l0 !== 1) begin
            errors++;
            $display("[TB] FAIL jitter_loss_count: got %0d expected 1", loss_q.size() - l0);
         end else begin
            checks++;
            if (loss_q[l0] - bv_cyc[b0+7] !== 21) begin
               errors++;
               $display("[TB] FAIL jitter_loss_time: got %0d expected 21", loss_q[l0] - bv_cyc[b0+7]);
            end
         end
      end
      checks++;
      if (locked !== 1'b0) begin errors++; $display("[TB] FAIL jitter_locked: got %b expected 0", locked); end
   endtask

   task automatic test_stuck();
      do_reset();
      toggle_after(1);
      for (int k = 0; k < 5; k++) toggle_after(16);
      repeat (80) @(negedge clk);
      checks++;
      if (bv_bits.size() - b0 !== 5 || loss_q.size() - l0 !== 1 || fall_q.size() - f0 !== 1) begin
         errors++;
         $display("[TB] FAIL stuck_counts: got bits=%0d loss=%0d falls=%0d expected 5/1/1",
                  bv_bits.size() - b0, loss_q.size() - l0, fall_q.size() - f0);
      end else begin
         checks++;
         if (loss_q[l0] - bv_cyc[b0+4] !== 21) begin
            errors++;
            $display("[TB] FAIL stuck_loss_time: got %0d expected 21", loss_q[l0] - bv_cyc[b0+4]);
         end
         checks++;
         if (fall_q[f0] !== loss_q[l0]) begin
            errors++;
            $display("[TB] FAIL stuck_lock_fall: got cycle %0d expected %0d", fall_q[f0], loss_q[l0]);
         end
      end
   endtask

   task automatic test_reset_relock();
      int rel;
      do_reset();
      toggle_after(1);
      for (int k = 0; k < 5; k++) toggle_after(16);
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (bit_valid !== 1'b1 || locked !== 1'b1 || bit_out !== 1'b1) begin
         errors++;
         $display("[TB] FAIL prereset_state: got valid=%b locked=%b bit=%b expected 1/1/1", bit_valid, locked, bit_out);
      end
      arst = 1'b1;
      #1;
      checks++;
      if (bit_valid !== 1'b0 || bit_out !== 1'b0 || locked !== 1'b0 || loss !== 1'b0) begin
         errors++;
         $display("[TB] FAIL async_reset: got valid=%b bit=%b locked=%b loss=%b expected 0/0/0/0",
                  bit_valid, bit_out, locked, loss);
      end
      @(negedge clk);
      arst = 1'b0;
      rel  = cyc;
      snapshot();
      for (int k = 0; k < 7; k++) toggle_after(16);
      repeat (6) @(negedge clk);
      checks++;
      if (rise_q.size() - r0 < 1) begin
         errors++;
         $display("[TB] FAIL relock: got no lock rise expected one within 96 cycles");
      end else if (rise_q[r0] - rel > 96) begin
         errors++;
         $display("[TB] FAIL relock_time: got %0d cycles expected <= 96", rise_q[r0] - rel);
      end
   endtask

`ifdef MAN_DECODER_PRBS_CHK_EN
   task automatic test_prbs();
      int e0;
      do_reset();
      e0 = perr_n;
      send_bit(1'b0);
      send_bit(1'b1);
      for (int k = 0; k < 36; k++) begin
         if (k == 20) begin
            checks++;
            if (prbs_sync !== 1'b1 || err_cnt !== 16'd0) begin
               errors++;
               $display("[TB] FAIL prbs_presync: got sync=%b err_cnt=%0d expected 1/0", prbs_sync, err_cnt);
            end
            send_bit(~prbs[k]);
         end else begin
            send_bit(prbs[k]);
         end
      end
      repeat (6) @(negedge clk);
      checks++;
      if (perr_n - e0 !== 5) begin errors++; $display("[TB] FAIL prbs_err_pulses: got %0d expected 5", perr_n - e0); end
      checks++;
      if (err_cnt !== 16'd5) begin errors++; $display("[TB] FAIL prbs_err_cnt: got %0d expected 5", err_cnt); end
      clr_cnt = 1'b1;
      @(negedge clk);
      clr_cnt = 1'b0;
      @(negedge clk);
      checks++;
      if (err_cnt !== 16'd0) begin errors++; $display("[TB] FAIL prbs_clear: got %0d expected 0", err_cnt); end
   endtask
`endif

   initial begin
      build_prbs();
      test_reset();
      test_nominal();
      test_phase();
      test_jitter();
      test_stuck();
      test_reset_relock();
`ifdef MAN_DECODER_PRBS_CHK_EN
      test_prbs();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/man_decoder.md
Name: man_decoder

Overview:
- Receive-side Manchester decoder paired with the team's Manchester line coder.
- Line convention: bit 1 is high-then-low; bit 0 is low-then-high; a transition occurs at every mid-bit.
- Oversamples the serial line on the system clock, recovers bit timing from mid-bit edges using a runtime bit-period divider, and emits decoded bits with a lock indication.
- Sits at the far end of the PRBS link, feeding bit-error measurement.

Parameters:
- CW, 13: width of div and of the bit-period count base.
- LOCK_BITS, 4: consecutive in-window mid-bit decodes required before locked asserts (1..15).
- W, 8: PRBS checker LFSR length (optional feature only).
- POLY, 9'h11D: PRBS polynomial, same encoding as the transmit LFSR (optional feature only).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- arst  in  1  asynchronous, active-high reset.
- div  in  CW  clocks per bit period; held static while locked; minimum 8.
- line_in  in  1  asynchronous Manchester serial input.
- bit_out  out  1  decoded bit; valid only while bit_valid is high.
- bit_valid  out  1  single-cycle strobe, one per decoded bit.
- locked  out  1  high after LOCK_BITS consecutive good decodes.
- loss  out  1  single-cycle pulse when an expected mid-bit edge is missing.

Behaviour:
- Reset (arst=1, asynchronous): state=HUNT; cnt=0; sync flops, prev, and good-decode counter=0; bit_out=0, bit_valid=0, locked=0, loss=0.
- Input path:
  - line_in passes through a 2-flop synchronizer (s1, s2), then prev<=s2.
  - edge = s2^prev.
  - The decoded bit value is prev, i.e. the level before the mid-bit edge.
- cnt: cycles since the last accepted edge, width CW+1, saturating at all-ones.
- Thresholds, computed combinationally from div:
  - q3 = div - (div>>2)
  - q5 = div + (div>>2)
  - Computed in CW+1 bits, no overflow.
- HUNT:
  - On edge with q3 <= cnt <= q5: the edge is a mid-bit edge. Emit the bit, set cnt<=0, set good-decode counter to 1, go to TRACK.
  - On any other edge: cnt<=0, stay in HUNT.
  - No edge: cnt increments.
- TRACK:
  - Edge with cnt < q3: boundary edge. Ignore it; cnt keeps counting.
  - Edge with q3 <= cnt <= q5: emit the bit, set cnt<=0, and increment the good-decode counter (saturating at LOCK_BITS).
  - cnt > q5 with no edge: loss pulses for one cycle, locked<=0, good-decode counter<=0, go to HUNT. cnt keeps counting, so the next edge re-hunts.
- Emission timing:
  - bit_valid and bit_out are registered the cycle after edge is detected.
  - Latency is 4 clk rising edges from the first clk edge that samples the new line_in level to bit_valid=1.
  - Bits are emitted in both HUNT and TRACK; locked is the consumer's qualifier.
- locked: registered; rises in the same cycle as the bit_valid of the LOCK_BITS-th good decode.
- Simultaneous events: an edge exactly at cnt==q5 is accepted (no loss). Loss is evaluated only when no edge is present that cycle.
- Changing div while locked is illegal. The required recovery is loss followed by relock within LOCK_BITS+2 bit periods.

Optional Feature:
- Macro: MAN_DECODER_PRBS_CHK_EN.
- When defined, the block adds:
  - Output prbs_err (1, single-cycle pulse).
  - Output err_cnt (16, saturating at 16'hFFFF).
  - Output prbs_sync (1).
  - Input clr_cnt (1, synchronous clear of err_cnt).
- Self-synchronizing checker:
  - hist[W-1:0] shifts in bit_out on each bit_valid while locked.
  - Prediction = XOR over d=1..W of POLY[d] & hist[d-1]. For the default polynomial the delays are 8, 4, 3, 2.
  - prbs_sync rises after W bits are shifted in while locked.
  - After prbs_sync, a mismatch pulses prbs_err and increments err_cnt.
  - Loss clears hist and prbs_sync.
- When not defined, these ports and this logic are absent.

Decomposition:
- Package man_pkg holds:
  - State encoding (HUNT, TRACK).
  - CW.
  - The default PRBS polynomial.
  - A threshold function returning q3/q5 from div.
- One sub-module: prbs_checker, instantiated only under MAN_DECODER_PRBS_CHK_EN.

Test Plan:
- Nominal decode:
  - Stimulus: div=16; encoder model driving transmit PRBS from seed 1.
  - Required: bits 1,0,1,1,0,0,0,1 decoded in order; locked rises on the 4th bit_valid.
  - Required: bit_valid spacing is exactly 16 cycles.
- Phase ambiguity: all-ones stream with edges every 8 cycles, started mid-bit.
  - Required: the first emitted bit comes from a 16-cycle edge gap.
  - Required: all emitted bits are 1; no loss.
- Jitter window: div=16, mid-bit edges at spacings 12, 20, 16.
  - Required: all three are accepted.
  - Spacing 11: the edge is ignored; loss pulses when cnt reaches 21; locked=0.
- Stuck line: hold line_in static after lock.
  - Required: exactly one loss pulse, 21 cycles after the last accepted edge; locked falls in the same cycle.
- Reset: assert arst mid-bit while locked.
  - Required: all outputs are 0 immediately (asynchronous).
  - Required: after release, relock within 6 bit periods.
- PRBS checker (macro on): flip one transmitted bit after prbs_sync.
  - Required: prbs_err pulses 5 times and err_cnt increments by exactly 5.
  - Required: clr_cnt returns err_cnt to 0.
